// File: rtl/cache_mem_serializer_pkg.sv
// Shared message formats and sizing for the 16B-to-4B memory serializer.
// The cache side speaks 16B line messages and the memory side speaks 4B word messages.
package cache_mem_serializer_pkg;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
    localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

    localparam int NBEATS     = 4;
    localparam int BEAT_IDX_W = 2;
    localparam int CNT_W      = 3;

    typedef struct packed {
        logic [2:0]   type_;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]   type_;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // A zero length means a whole line; anything else fits in one word.
    function automatic logic [CNT_W-1:0] beatCount(input logic [3:0] len);
        return (len == 4'd0) ? CNT_W'(NBEATS) : CNT_W'(1);
    endfunction

endpackage

// File: rtl/cache_mem_serializer_assembler.sv
// Line assembly register: four 32b slots written independently by beat index,
// so memory may return beats in any order.
module cache_line_assembler
    import cache_mem_serializer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  wrEn_i,
    input  logic [BEAT_IDX_W-1:0] slot_i,
    input  logic [31:0]           word_i,
    output logic [127:0]          line_o
);

    logic [NBEATS-1:0][31:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (clear_i) begin
            line_d = '0;
        end else if (wrEn_i) begin
            line_d[slot_i] = word_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/cache_mem_serializer.sv
// Splits one 16B cache memory request into 4B beats and merges the beat
// responses back into a single 16B response; one transaction in flight.
module cache_mem_serializer
    import cache_mem_serializer_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  mem_req_16B_t  cache2mem_reqstream_msg,
    input  logic          cache2mem_reqstream_val,
    output logic          cache2mem_reqstream_rdy,
    output mem_resp_16B_t cache2mem_respstream_msg,
    output logic          cache2mem_respstream_val,
    input  logic          cache2mem_respstream_rdy,
    output mem_req_4B_t   mem_reqstream_msg,
    output logic          mem_reqstream_val,
    input  logic          mem_reqstream_rdy,
    input  mem_resp_4B_t  mem_respstream_msg,
    input  logic          mem_respstream_val,
    output logic          mem_respstream_rdy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      reqCnt_q, reqCnt_d;
    logic [CNT_W-1:0]      respCnt_q, respCnt_d;
    mem_req_16B_t          req_q, req_d;

    logic                  acceptFire, beatReqFire, beatRespFire, respFire;
    logic                  fullLine;
    logic [CNT_W-1:0]      nbeats;
    logic [BEAT_IDX_W-1:0] beatIdx;
    logic [127:0]          line;
    mem_req_4B_t           beat;
    logic                  unusedRespBits;

    assign fullLine     = (req_q.len == 4'd0);
    assign nbeats       = beatCount(req_q.len);
    assign beatIdx      = reqCnt_q[BEAT_IDX_W-1:0];

    assign cache2mem_reqstream_rdy  = (state_q == ST_IDLE);
    assign cache2mem_respstream_val = (state_q == ST_RESP);
    assign mem_reqstream_val        = (state_q == ST_XFER) && (reqCnt_q < nbeats);
    assign mem_respstream_rdy       = (state_q != ST_RESP);

    assign acceptFire   = cache2mem_reqstream_val && cache2mem_reqstream_rdy;
    assign beatReqFire  = mem_reqstream_val && mem_reqstream_rdy;
    assign beatRespFire = mem_respstream_val && mem_respstream_rdy;
    assign respFire     = cache2mem_respstream_val && cache2mem_respstream_rdy;

    // Only opaque[1:0] and data of a beat response carry meaning here.
    assign unusedRespBits = ^{mem_respstream_msg.type_, mem_respstream_msg.opaque[7:2],
                              mem_respstream_msg.test, mem_respstream_msg.len};

    always_comb begin
        beat = '0;
        if (fullLine) begin
            beat.type_  = req_q.type_;
            beat.opaque = {6'b0, beatIdx};
            beat.addr   = {req_q.addr[31:4], beatIdx, 2'b00};
            beat.len    = 2'd0;
            beat.data   = req_q.data[{beatIdx, 5'b0} +: 32];
        end else begin
            beat.type_  = req_q.type_;
            beat.addr   = req_q.addr;
            beat.len    = req_q.len[1:0];
            beat.data   = req_q.data[31:0];
        end
    end

    assign mem_reqstream_msg = mem_reqstream_val ? beat : '0;

    always_comb begin
        cache2mem_respstream_msg = '0;
        if (state_q == ST_RESP) begin
            cache2mem_respstream_msg.type_  = req_q.type_;
            cache2mem_respstream_msg.opaque = req_q.opaque;
            cache2mem_respstream_msg.len    = req_q.len;
            cache2mem_respstream_msg.data   = (req_q.type_ == MEM_TYPE_READ) ? line : 128'd0;
        end
    end

    cache_line_assembler assembler (
        .clk     (clk),
        .reset   (reset),
        .clear_i (respFire),
        .wrEn_i  ((state_q == ST_XFER) && beatRespFire),
        .slot_i  (mem_respstream_msg.opaque[BEAT_IDX_W-1:0]),
        .word_i  (mem_respstream_msg.data),
        .line_o  (line)
    );

    // Issue and collect counters advance independently; the last collected beat ends XFER.
    always_comb begin
        state_d   = state_q;
        reqCnt_d  = reqCnt_q;
        respCnt_d = respCnt_q;
        req_d     = req_q;
        case (state_q)
            ST_IDLE: begin
                if (acceptFire) begin
                    req_d     = cache2mem_reqstream_msg;
                    reqCnt_d  = '0;
                    respCnt_d = '0;
                    state_d   = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beatReqFire) begin
                    reqCnt_d = reqCnt_q + CNT_W'(1);
                end
                if (beatRespFire) begin
                    respCnt_d = respCnt_q + CNT_W'(1);
                    if (respCnt_q + CNT_W'(1) == nbeats) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (respFire) begin
                    reqCnt_d  = '0;
                    respCnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            reqCnt_q  <= '0;
            respCnt_q <= '0;
            req_q     <= '0;
        end else begin
            state_q   <= state_d;
            reqCnt_q  <= reqCnt_d;
            respCnt_q <= respCnt_d;
            req_q     <= req_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_serializer.sv
// Scoreboard bench for cache_mem_serializer: directed transactions push expected
// beats and responses; monitors on both ports pop and compare as the DUT emits them.
module tb_cache_mem_serializer;
    import cache_mem_serializer_pkg::*;

    logic          clk;
    logic          reset;
    mem_req_16B_t  reqMsg;
    logic          reqVal;
    logic          reqRdy;
    mem_resp_16B_t respMsg;
    logic          respVal;
    logic          respRdy;
    mem_req_4B_t   mreqMsg;
    logic          mreqVal;
    logic          mreqRdy;
    mem_resp_4B_t  mrespMsg;
    logic          mrespVal;
    logic          mrespRdy;

    int total = 0;
    int bad = 0;

    mem_req_4B_t   expBeats[$];
    mem_resp_16B_t expResps[$];
    mem_resp_4B_t  pending[$];
    logic [31:0]   memory[logic [31:0]];

    int beatsSeen = 0;
    int beatBudget = -1;
    bit rndMode = 0;
    bit memHold = 0;
    bit oooMode = 0;
    bit oooReady = 0;
    int acceptCount = 0;
    int respCount = 0;
    int dropCount = 0;

    cache_mem_serializer dut (
        .clk                      (clk),
        .reset                    (reset),
        .cache2mem_reqstream_msg  (reqMsg),
        .cache2mem_reqstream_val  (reqVal),
        .cache2mem_reqstream_rdy  (reqRdy),
        .cache2mem_respstream_msg (respMsg),
        .cache2mem_respstream_val (respVal),
        .cache2mem_respstream_rdy (respRdy),
        .mem_reqstream_msg        (mreqMsg),
        .mem_reqstream_val        (mreqVal),
        .mem_reqstream_rdy        (mreqRdy),
        .mem_respstream_msg       (mrespMsg),
        .mem_respstream_val       (mrespVal),
        .mem_respstream_rdy       (mrespRdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout/unexpected expected event", name);
    endtask

    function automatic mem_req_16B_t mkReq(input logic [2:0] t, input logic [7:0] o,
                                           input logic [31:0] a, input logic [3:0] l,
                                           input logic [127:0] d);
        mem_req_16B_t m;
        m.type_ = t; m.opaque = o; m.addr = a; m.len = l; m.data = d;
        return m;
    endfunction

    function automatic mem_resp_16B_t mkResp(input logic [2:0] t, input logic [7:0] o,
                                             input logic [3:0] l, input logic [127:0] d);
        mem_resp_16B_t m;
        m.type_ = t; m.opaque = o; m.test = 2'd0; m.len = l; m.data = d;
        return m;
    endfunction

    function automatic mem_req_4B_t mkBeat(input logic [2:0] t, input logic [7:0] o,
                                           input logic [31:0] a, input logic [1:0] l,
                                           input logic [31:0] d);
        mem_req_4B_t m;
        m.type_ = t; m.opaque = o; m.addr = a; m.len = l; m.data = d;
        return m;
    endfunction

    // Cache-side monitor: response compare, hold stability, single outstanding transaction.
    initial begin
        bit held;
        mem_resp_16B_t heldMsg;
        held = 0;
        heldMsg = '0;
        forever begin
            @(negedge clk);
            if (held) begin
                checkOutput("resp held valid", 256'(respVal), 256'(1'b1));
                checkOutput("resp held stable", 256'(respMsg), 256'(heldMsg));
            end
            held = respVal && !respRdy && reset;
            heldMsg = respMsg;
            if (reqVal && reqRdy && reset) begin
                checkOutput("single outstanding", 256'(acceptCount - respCount - dropCount), 256'(0));
                acceptCount++;
            end
            if (respVal && respRdy && reset) begin
                if (expResps.size() == 0) begin
                    failNow("unexpected resp");
                end else begin
                    checkOutput("resp msg", 256'(respMsg), 256'(expResps.pop_front()));
                    respCount++;
                end
            end
        end
    end

    // Memory model: checks beats, stores writes, answers reads, optionally reorders.
    initial begin
        bit taken;
        mem_req_4B_t b;
        mem_resp_4B_t r, t0, t1, t2, t3;
        mrespVal = 1'b0;
        mrespMsg = '0;
        mreqRdy = 1'b1;
        forever begin
            @(negedge clk);
            taken = mrespVal && mrespRdy;
            if (mreqVal && mreqRdy && reset) begin
                b = mreqMsg;
                beatsSeen++;
                if (beatBudget > 0) beatBudget--;
                if (expBeats.size() == 0) failNow("unexpected beat");
                else checkOutput("beat msg", 256'(b), 256'(expBeats.pop_front()));
                r.type_ = b.type_;
                r.opaque = b.opaque;
                r.test = 2'd0;
                r.len = b.len;
                if (b.type_ == MEM_TYPE_WRITE) begin
                    memory[b.addr] = b.data;
                    r.data = 32'd0;
                end else begin
                    r.data = memory.exists(b.addr) ? memory[b.addr] : 32'd0;
                end
                pending.push_back(r);
                if (oooMode && pending.size() == 4) begin
                    t0 = pending[0]; t1 = pending[1]; t2 = pending[2]; t3 = pending[3];
                    pending.delete();
                    pending.push_back(t2);
                    pending.push_back(t0);
                    pending.push_back(t3);
                    pending.push_back(t1);
                    oooReady = 1;
                end
            end
            @(posedge clk);
            #1;
            if (taken) begin
                mrespVal = 1'b0;
                mrespMsg = '0;
            end
            mreqRdy = (beatBudget != 0) && (rndMode ? ($urandom_range(0, 2) != 0) : 1'b1);
            if (!mrespVal && pending.size() > 0 && !memHold && (!oooMode || oooReady)
                && (!rndMode || $urandom_range(0, 2) == 0)) begin
                mrespMsg = pending.pop_front();
                mrespVal = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input mem_req_16B_t m);
        int n;
        reqMsg = m;
        reqVal = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (reqRdy) break;
            n++;
            if (n > 2000) begin
                failNow("accept timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        reqVal = 1'b0;
        reqMsg = '0;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (expResps.size() == 0 && expBeats.size() == 0 && !respVal) break;
            n++;
            if (n > 2000) begin
                failNow("transaction timeout");
                break;
            end
        end
        checkOutput("beats drained", 256'(expBeats.size()), 256'(0));
        checkOutput("resps drained", 256'(expResps.size()), 256'(0));
    endtask

    task automatic pushFullRead(input logic [31:0] a, input logic [7:0] o, input logic [127:0] d);
        for (int i = 0; i < 4; i++) begin
            expBeats.push_back(mkBeat(MEM_TYPE_READ, 8'(i), a + 32'(4 * i), 2'd0, 32'd0));
        end
        expResps.push_back(mkResp(MEM_TYPE_READ, o, 4'd0, d));
    endtask

    initial begin
        int base;
        int n;
        reset = 1'b0;
        reqVal = 1'b0;
        reqMsg = '0;
        respRdy = 1'b1;
        memory[32'h1000] = 32'h11; memory[32'h1004] = 32'h22;
        memory[32'h1008] = 32'h33; memory[32'h100C] = 32'h44;
        memory[32'h4000] = 32'hA0A0A0A0; memory[32'h4004] = 32'hA1A1A1A1;
        memory[32'h4008] = 32'hA2A2A2A2; memory[32'h400C] = 32'hA3A3A3A3;
        memory[32'h3006] = 32'hCAFEBABE;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset req rdy", 256'(reqRdy), 256'(1'b1));
        checkOutput("reset resp val", 256'(respVal), 256'(1'b0));
        checkOutput("reset mreq val", 256'(mreqVal), 256'(1'b0));
        checkOutput("reset mresp rdy", 256'(mrespRdy), 256'(1'b1));
        checkOutput("reset resp msg", 256'(respMsg), 256'(0));
        checkOutput("reset mreq msg", 256'(mreqMsg), 256'(0));
        @(posedge clk);
        #1;

        $display("[TB] full-line read");
        pushFullRead(32'h1000, 8'h2A, 128'h00000044_00000033_00000022_00000011);
        applyStimulus(mkReq(MEM_TYPE_READ, 8'h2A, 32'h1000, 4'd0, 128'd0));
        waitDone();

        $display("[TB] full-line write");
        expBeats.push_back(mkBeat(MEM_TYPE_WRITE, 8'd0, 32'h2010, 2'd0, 32'hAAAA));
        expBeats.push_back(mkBeat(MEM_TYPE_WRITE, 8'd1, 32'h2014, 2'd0, 32'hBBBB));
        expBeats.push_back(mkBeat(MEM_TYPE_WRITE, 8'd2, 32'h2018, 2'd0, 32'hCCCC));
        expBeats.push_back(mkBeat(MEM_TYPE_WRITE, 8'd3, 32'h201C, 2'd0, 32'hDDDD));
        expResps.push_back(mkResp(MEM_TYPE_WRITE, 8'h05, 4'd0, 128'd0));
        applyStimulus(mkReq(MEM_TYPE_WRITE, 8'h05, 32'h2010, 4'd0,
                            128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA));
        waitDone();

        $display("[TB] out-of-order read");
        oooMode = 1;
        pushFullRead(32'h1000, 8'h2B, 128'h00000044_00000033_00000022_00000011);
        applyStimulus(mkReq(MEM_TYPE_READ, 8'h2B, 32'h1000, 4'd0, 128'd0));
        waitDone();
        oooMode = 0;
        oooReady = 0;

        $display("[TB] backpressure");
        rndMode = 1;
        respRdy = 1'b0;
        pushFullRead(32'h4000, 8'h3C, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
        expBeats.push_back(mkBeat(MEM_TYPE_WRITE, 8'd0, 32'h5000, 2'd0, 32'h12345678));
        expResps.push_back(mkResp(MEM_TYPE_WRITE, 8'h44, 4'd4, 128'd0));
        fork
            begin
                int w;
                w = 0;
                while (!respVal && w < 2000) begin
                    @(negedge clk);
                    w++;
                end
                repeat (5) @(posedge clk);
                #1;
                respRdy = 1'b1;
            end
        join_none
        applyStimulus(mkReq(MEM_TYPE_READ, 8'h3C, 32'h4000, 4'd0, 128'd0));
        applyStimulus(mkReq(MEM_TYPE_WRITE, 8'h44, 32'h5000, 4'd4,
                            128'hFFFF0000_EEEE0000_DDDD0000_12345678));
        waitDone();
        rndMode = 0;
        respRdy = 1'b1;

        $display("[TB] single word read");
        expBeats.push_back(mkBeat(MEM_TYPE_READ, 8'd0, 32'h3006, 2'd2, 32'd0));
        expResps.push_back(mkResp(MEM_TYPE_READ, 8'h07, 4'd2, 128'hCAFEBABE));
        applyStimulus(mkReq(MEM_TYPE_READ, 8'h07, 32'h3006, 4'd2, 128'd0));
        waitDone();

        $display("[TB] reset mid-transfer");
        memHold = 1;
        beatBudget = 2;
        base = beatsSeen;
        expBeats.push_back(mkBeat(MEM_TYPE_READ, 8'd0, 32'h6000, 2'd0, 32'd0));
        expBeats.push_back(mkBeat(MEM_TYPE_READ, 8'd1, 32'h6004, 2'd0, 32'd0));
        applyStimulus(mkReq(MEM_TYPE_READ, 8'h11, 32'h6000, 4'd0, 128'd0));
        n = 0;
        while (beatsSeen < base + 2 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("beats before reset", 256'(beatsSeen - base), 256'(2));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        dropCount++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post-reset req rdy", 256'(reqRdy), 256'(1'b1));
        checkOutput("post-reset resp val", 256'(respVal), 256'(1'b0));
        checkOutput("post-reset mreq val", 256'(mreqVal), 256'(1'b0));
        beatBudget = -1;
        memHold = 0;
        n = 0;
        while ((pending.size() > 0 || mrespVal) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("stale responses drained", 256'(pending.size()), 256'(0));
        @(negedge clk);
        checkOutput("stale no resp", 256'(respVal), 256'(1'b0));
        @(posedge clk);
        #1;
        pushFullRead(32'h1000, 8'h2C, 128'h00000044_00000033_00000022_00000011);
        applyStimulus(mkReq(MEM_TYPE_READ, 8'h2C, 32'h1000, 4'd0, 128'd0));
        waitDone();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
